id_ex_skid_stage: RTL

ID_EX_SKID_STAGE -- requirements
Module: id_ex_skid_stage

---
 rtl/id_ex_skid_stage.sv | 134 +++++++++++++
 1 files changed

// File: rtl/id_ex_skid_stage.sv
// ID/EX pipeline register with optional two-entry skid buffer between decode and execute.
// Latency: one cycle from accept into an empty stage to out_valid.
// Backpressure: SKID=1 gives a registered in_ready (!skid valid); SKID=0 passes out_ready through combinationally.
module id_ex_skid_stage #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 32,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [15:0]       stall_cnt
);

  logic              main_vld_q, main_vld_d;
  logic [DATA_W-1:0] main_dat_q, main_dat_d;
  logic [CTRL_W-1:0] main_ctl_q, main_ctl_d;
  logic              skid_vld_q, skid_vld_d;
  logic [DATA_W-1:0] skid_dat_q, skid_dat_d;
  logic [CTRL_W-1:0] skid_ctl_q, skid_ctl_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;

  logic accept;
  logic issue;
  logic main_free;

  // Ready is gated by rst_n so nothing can be accepted while reset is held.
  // With SKID=1 it depends only on held state, cutting the out_ready timing path.
  assign in_ready  = (SKID != 0) ? (rst_n && !skid_vld_q)
                                 : (rst_n && (!main_vld_q || out_ready));
  assign accept    = in_valid && in_ready && !flush;
  assign issue     = main_vld_q && out_ready;
  assign main_free = !main_vld_q || issue;

  assign out_valid = main_vld_q;
  assign out_data  = main_dat_q;
  assign out_ctrl  = main_vld_q ? main_ctl_q : '0;
  assign occupancy = {1'b0, main_vld_q} + {1'b0, skid_vld_q};
  assign stall_cnt = stall_cnt_q;

  // Next-state for main/skid entries: in-order refill, skid drains into main first, flush wins.
  always_comb begin
    main_vld_d = main_vld_q;
    main_dat_d = main_dat_q;
    main_ctl_d = main_ctl_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    skid_ctl_d = skid_ctl_q;

    if (SKID != 0) begin
      if (main_free) begin
        if (skid_vld_q) begin
          // Older skid entry moves forward; a same-cycle accept refills skid.
          main_vld_d = 1'b1;
          main_dat_d = skid_dat_q;
          main_ctl_d = skid_ctl_q;
          skid_vld_d = accept;
          if (accept) begin
            skid_dat_d = in_data;
            skid_ctl_d = in_ctrl;
          end
        end else if (accept) begin
          main_vld_d = 1'b1;
          main_dat_d = in_data;
          main_ctl_d = in_ctrl;
        end else begin
          main_vld_d = 1'b0;
        end
      end else if (accept) begin
        // Main is stalled, so the new entry parks in skid.
        skid_vld_d = 1'b1;
        skid_dat_d = in_data;
        skid_ctl_d = in_ctrl;
      end
    end else begin
      if (main_free) begin
        main_vld_d = accept;
        if (accept) begin
          main_dat_d = in_data;
          main_ctl_d = in_ctrl;
        end
      end
    end

    // Flush kills valid and control but leaves data untouched (data regs need no clear).
    if (flush) begin
      main_vld_d = 1'b0;
      main_ctl_d = '0;
      main_dat_d = main_dat_q;
      skid_vld_d = 1'b0;
      skid_ctl_d = '0;
      skid_dat_d = skid_dat_q;
    end
  end

  // Saturating count of cycles where decode offers an entry we cannot take.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid && !in_ready && !flush && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_vld_q  <= 1'b0;
      main_dat_q  <= '0;
      main_ctl_q  <= '0;
      skid_vld_q  <= 1'b0;
      skid_dat_q  <= '0;
      skid_ctl_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      main_vld_q  <= main_vld_d;
      main_dat_q  <= main_dat_d;
      main_ctl_q  <= main_ctl_d;
      skid_vld_q  <= skid_vld_d;
      skid_dat_q  <= skid_dat_d;
      skid_ctl_q  <= skid_ctl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
